tank_address_latch_f2_up: RTL and testbench
===========================================

// Module: tank_address_latch_f2_up
// PURPOSE
// - Upstream stage of the F2-up tank decoder. During an order-fetch minor cycle it captures the two
//   tank-select bits from the serial order stream into flip-flops F7/F8, driven as complementary pos/neg pairs.
// - Generates the t_in/t_out transfer gates, aligned to minor-cycle boundaries, that the decoder
//   steers to one of tanks T0..T3.
// PARAMETERS
// - DIGITS_PER_MC  18  digit pulses per minor cycle (counter range 0..DIGITS_PER_MC-1)
// - F7_POS          1  digit position of the F7 bit within the order word (serial, LSB first)
// - F8_POS          2  digit position of the F8 bit; must be < DIGITS_PER_MC and != F7_POS
// PORTS
// - clk             in   1  system clock
// - rst_n           in   1  asynchronous active-low reset
// - digit_pulse     in   1  one-clk strobe per digit period; advances the digit counter
// - mc_sync         in   1  one-clk strobe coincident with the digit_pulse of digit 0; resyncs the counter
// - order_serial    in   1  serial order bit, valid on the clk where digit_pulse=1
// - addr_capture    in   1  level; high for the whole minor cycle that carries the order
// - xfer_in_req     in   1  level request: write into the selected tank; held until xfer_ack
// - xfer_out_req    in   1  level request: read from the selected tank; held until xfer_ack
// - xfer_ack        out  1  one-clk pulse on the last digit of the transfer window
// - f2_up_f7_pos    out  1  F7 true
// - f2_up_f7_neg    out  1  F7 complement
// - f2_up_f8_pos    out  1  F8 true
// - f2_up_f8_neg    out  1  F8 complement
// - f2_up_t_in      out  1  write gate to the decoder
// - f2_up_t_out     out  1  read gate to the decoder
// - addr_valid      out  1  F7/F8 hold a committed address
// BEHAVIOUR
// - Reset: digit counter=0, state=IDLE, F7=F8=0 (pos=0, neg=1), t_in=t_out=xfer_ack=addr_valid=0.
//   The asynchronous reset aborts any open window immediately.
// - Digit counter: advances on digit_pulse and wraps DIGITS_PER_MC-1 -> 0. mc_sync forces the count to 0.
// - Capture: with addr_capture=1 and digit_pulse=1, bits at F7_POS and F8_POS are sampled into shadow
//   registers. The shadow commits to F7/F8 on the digit_pulse of the last digit, and addr_valid then goes to 1.
// - F7/F8 change only at a minor-cycle boundary, never mid-cycle. pos/neg are always exact complements.
// - If addr_capture drops before the last digit, nothing is committed: F7/F8 and addr_valid keep their old values.
// - State machine, one-hot:
//   - IDLE -> ARMED when addr_valid=1 and either req is high (sampled on any clk).
//   - ARMED -> XFER on the next counter wrap to digit 0.
//     - t_in or t_out goes high at that digit-0 digit_pulse.
//     - It stays high for exactly DIGITS_PER_MC digit periods.
//   - XFER -> DONE on the last digit_pulse; xfer_ack pulses for that one clk and the gate drops.
//   - DONE -> IDLE on the next clk. The request must be low by then, or it re-arms.
// - Simultaneous in and out requests: out has priority; in remains pending for the next window.
//   t_in and t_out are never both 1.
// - A request dropped while ARMED returns the FSM to IDLE with no gate. A request dropped during XFER
//   does not truncate the window.
// - A new capture during XFER updates only the shadow. The commit is deferred until the window ends,
//   so the address stays stable under the gate.
// - Gates and F7/F8 are registered; gates lag the digit_pulse by 1 clk.
// CONFIGURATION
// - F2_UP_LONG_XFER_EN defined:
//   - the window spans 2*DIGITS_PER_MC digits (long number, two minor cycles);
//   - xfer_ack pulses on the last digit of the second minor cycle.
// - Undefined: single-minor-cycle window only.
// STRUCTURE
// - edsac_ctrl_pkg: DIGITS_PER_MC default, xfer_state_t enum {IDLE,ARMED,XFER,DONE}, digit counter width
//   function clog2(DIGITS_PER_MC).
// - Sub-module minor_cycle_counter (digit counter, mc_sync resync, last_digit/first_digit strobes); this
//   sub-module is shared with other control-section stages.
// TESTING
// - Reset mid-XFER (t_out=1, digit 9) -> t_out=0, f7_neg=f8_neg=1, addr_valid=0 at once.
// - Capture with order bits at positions 1,2 = 1,0 -> after digit 17, f7_pos=1/f7_neg=0, f8_pos=0/f8_neg=1,
//   addr_valid=1. f7_pos stays 0 through digits 0..16.
// - xfer_in_req held at digit 5 -> t_in rises at the next digit 0, is high for 18 digit_pulses,
//   xfer_ack pulses once at digit 17, t_out stays 0 throughout.
// - xfer_in_req and xfer_out_req both high -> first window gives t_out; with in_req still high,
//   the second window gives t_in. No overlap.
// - addr_capture dropped at digit 10 -> F7/F8 unchanged. Recapture during XFER -> F7/F8 change only
//   after the xfer_ack clk.
// - With F2_UP_LONG_XFER_EN defined, t_out stays high 36 digit_pulses and xfer_ack comes at the 36th.

Source files
------------

// File: rtl/edsac_ctrl_pkg.sv
// edsac_ctrl_pkg
//   Shared definitions for the control-section stages: default minor-cycle
//   length, the transfer-window state encoding and the digit-counter width
//   helper.
package edsac_ctrl_pkg;

   localparam int unsigned DIGITS_PER_MC_DEF = 18;

   // One-hot so each state is a single flip-flop; DONE doubles as xfer_ack.
   typedef enum logic [3:0] {
      IDLE  = 4'b0001,
      ARMED = 4'b0010,
      XFER  = 4'b0100,
      DONE  = 4'b1000
   } xfer_state_t;

   // Bits needed to count 0..n-1 (never less than 1).
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned w;
      w = 1;
      while ((32'd1 << w) < n) w = w + 1;
      return w;
   endfunction

endpackage

// File: rtl/minor_cycle_counter.sv
// minor_cycle_counter
//   Digit counter for one minor cycle, shared by the control-section stages.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     digit_pulse  one-clk strobe per digit period; advances the count
//     mc_sync      strobe coincident with the digit-0 pulse; forces count 0
//     digit_idx    index of the digit being presented on this clk
//     first_digit  digit_pulse of digit 0
//     last_digit   digit_pulse of digit DIGITS_PER_MC-1
module minor_cycle_counter
   import edsac_ctrl_pkg::*;
#(
   parameter int unsigned DIGITS_PER_MC = DIGITS_PER_MC_DEF
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             digit_pulse,
   input  logic                             mc_sync,
   output logic [clog2(DIGITS_PER_MC)-1:0]  digit_idx,
   output logic                             first_digit,
   output logic                             last_digit
);

   localparam int unsigned    CW   = clog2(DIGITS_PER_MC);
   localparam logic [CW-1:0]  LAST = CW'(DIGITS_PER_MC - 1);

   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_digit;

   // mc_sync names the current pulse digit 0 regardless of the stored count.
   assign w_digit = mc_sync ? '0 : r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (digit_pulse) begin
         r_cnt <= (w_digit == LAST) ? '0 : w_digit + 1'b1;
      end else if (mc_sync) begin
         r_cnt <= '0;
      end
   end

   assign digit_idx   = w_digit;
   assign first_digit = digit_pulse & (w_digit == '0);
   assign last_digit  = digit_pulse & (w_digit == LAST);

endmodule

// File: rtl/tank_address_latch_f2_up.sv
// tank_address_latch_f2_up
//   Upstream stage of the F2-up tank decoder. Captures the two tank-select
//   bits F7/F8 from the serial order stream and generates minor-cycle aligned
//   t_in/t_out transfer gates.
//   Build option: F2_UP_LONG_XFER_EN -- transfer window spans two minor
//   cycles (long number) instead of one.
//   Ports:
//     clk, rst_n                 clock, asynchronous active-low reset
//     digit_pulse, mc_sync       digit timing strobes
//     order_serial               serial order bit, valid with digit_pulse
//     addr_capture               level, high for the order minor cycle
//     xfer_in_req/xfer_out_req   level requests, held until xfer_ack
//     xfer_ack                   one-clk pulse at the end of the window
//     f2_up_f7_pos/neg, f2_up_f8_pos/neg   complementary address pairs
//     f2_up_t_in, f2_up_t_out    registered transfer gates
//     addr_valid                 F7/F8 hold a committed address
module tank_address_latch_f2_up
   import edsac_ctrl_pkg::*;
#(
   parameter int unsigned DIGITS_PER_MC = DIGITS_PER_MC_DEF,
   parameter int unsigned F7_POS        = 1,
   parameter int unsigned F8_POS        = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic digit_pulse,
   input  logic mc_sync,
   input  logic order_serial,
   input  logic addr_capture,
   input  logic xfer_in_req,
   input  logic xfer_out_req,
   output logic xfer_ack,
   output logic f2_up_f7_pos,
   output logic f2_up_f7_neg,
   output logic f2_up_f8_pos,
   output logic f2_up_f8_neg,
   output logic f2_up_t_in,
   output logic f2_up_t_out,
   output logic addr_valid
);

   localparam int unsigned    CW     = clog2(DIGITS_PER_MC);
   localparam logic [CW-1:0]  F7_IDX = CW'(F7_POS);
   localparam logic [CW-1:0]  F8_IDX = CW'(F8_POS);

   logic [CW-1:0] w_digit;
   logic          w_first;
   logic          w_last;

   minor_cycle_counter #(
      .DIGITS_PER_MC (DIGITS_PER_MC)
   ) u_mc_cnt (
      .clk         (clk),
      .rst_n       (rst_n),
      .digit_pulse (digit_pulse),
      .mc_sync     (mc_sync),
      .digit_idx   (w_digit),
      .first_digit (w_first),
      .last_digit  (w_last)
   );

   xfer_state_t r_state, w_state_nxt;
   logic        r_t_in, w_t_in_nxt;
   logic        r_t_out, w_t_out_nxt;
   logic        r_sh_f7, r_sh_f8;
   logic        w_sh_f7_nxt, w_sh_f8_nxt;
   logic        r_cap_ok;
   logic        r_pend;
   logic        r_f7, r_f8;
   logic        r_valid;
   logic        w_cap_done;
   logic        w_req;

   // Shadow next values feed the commit directly so a select bit sitting on
   // the last digit is not missed.
   assign w_sh_f7_nxt = (digit_pulse && addr_capture && (w_digit == F7_IDX)) ? order_serial : r_sh_f7;
   assign w_sh_f8_nxt = (digit_pulse && addr_capture && (w_digit == F8_IDX)) ? order_serial : r_sh_f8;

   // Capture completes only if addr_capture was high on every digit.
   assign w_cap_done  = w_last & r_cap_ok & addr_capture;
   assign w_req       = xfer_in_req | xfer_out_req;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sh_f7  <= 1'b0;
         r_sh_f8  <= 1'b0;
         r_cap_ok <= 1'b0;
         r_pend   <= 1'b0;
         r_f7     <= 1'b0;
         r_f8     <= 1'b0;
         r_valid  <= 1'b0;
      end else begin
         r_sh_f7 <= w_sh_f7_nxt;
         r_sh_f8 <= w_sh_f8_nxt;
         if (digit_pulse) begin
            r_cap_ok <= w_first ? addr_capture : (r_cap_ok & addr_capture);
         end
         // A capture finishing under an open window is held back until the
         // window has closed, keeping the address stable under the gate.
         if (w_cap_done && (r_state != XFER)) begin
            r_f7    <= w_sh_f7_nxt;
            r_f8    <= w_sh_f8_nxt;
            r_valid <= 1'b1;
            r_pend  <= 1'b0;
         end else if (w_cap_done) begin
            r_pend  <= 1'b1;
         end else if (r_pend && (r_state != XFER)) begin
            r_f7    <= r_sh_f7;
            r_f8    <= r_sh_f8;
            r_valid <= 1'b1;
            r_pend  <= 1'b0;
         end
      end
   end

`ifdef F2_UP_LONG_XFER_EN
   logic r_mc2, w_mc2_nxt;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_t_in  <= 1'b0;
         r_t_out <= 1'b0;
`ifdef F2_UP_LONG_XFER_EN
         r_mc2   <= 1'b0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_t_in  <= w_t_in_nxt;
         r_t_out <= w_t_out_nxt;
`ifdef F2_UP_LONG_XFER_EN
         r_mc2   <= w_mc2_nxt;
`endif
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_t_in_nxt  = r_t_in;
      w_t_out_nxt = r_t_out;
`ifdef F2_UP_LONG_XFER_EN
      w_mc2_nxt   = r_mc2;
`endif
      case (r_state)
         IDLE: begin
            if (r_valid && w_req) w_state_nxt = ARMED;
         end
         ARMED: begin
            if (!w_req) begin
               w_state_nxt = IDLE;
            end else if (w_first) begin
               // Out wins a tie; a held in request gets the next window.
               w_state_nxt = XFER;
               w_t_out_nxt = xfer_out_req;
               w_t_in_nxt  = ~xfer_out_req;
`ifdef F2_UP_LONG_XFER_EN
               w_mc2_nxt   = 1'b0;
`endif
            end
         end
         XFER: begin
            if (w_last) begin
`ifdef F2_UP_LONG_XFER_EN
               if (r_mc2) begin
                  w_state_nxt = DONE;
                  w_t_in_nxt  = 1'b0;
                  w_t_out_nxt = 1'b0;
                  w_mc2_nxt   = 1'b0;
               end else begin
                  w_mc2_nxt   = 1'b1;
               end
`else
               w_state_nxt = DONE;
               w_t_in_nxt  = 1'b0;
               w_t_out_nxt = 1'b0;
`endif
            end
         end
         DONE: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
            w_t_in_nxt  = 1'b0;
            w_t_out_nxt = 1'b0;
         end
      endcase
   end

   assign xfer_ack     = (r_state == DONE);
   assign f2_up_f7_pos = r_f7;
   assign f2_up_f7_neg = ~r_f7;
   assign f2_up_f8_pos = r_f8;
   assign f2_up_f8_neg = ~r_f8;
   assign f2_up_t_in   = r_t_in;
   assign f2_up_t_out  = r_t_out;
   assign addr_valid   = r_valid;

endmodule

// File: tb/tb_tank_address_latch_f2_up.sv
module tb_tank_address_latch_f2_up;

   localparam int unsigned DPM  = 18;
   localparam int unsigned NONE = 999;
`ifdef F2_UP_LONG_XFER_EN
   localparam int unsigned WIN  = 2 * DPM;
`else
   localparam int unsigned WIN  = DPM;
`endif

   logic clk = 1'b0;
   logic rst_n, digit_pulse, mc_sync, order_serial, addr_capture;
   logic xfer_in_req, xfer_out_req;
   logic xfer_ack, f7_pos, f7_neg, f8_pos, f8_neg, t_in, t_out, addr_valid;

   always #5 clk = ~clk;

   tank_address_latch_f2_up #(
      .DIGITS_PER_MC (DPM),
      .F7_POS        (1),
      .F8_POS        (2)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .digit_pulse  (digit_pulse),
      .mc_sync      (mc_sync),
      .order_serial (order_serial),
      .addr_capture (addr_capture),
      .xfer_in_req  (xfer_in_req),
      .xfer_out_req (xfer_out_req),
      .xfer_ack     (xfer_ack),
      .f2_up_f7_pos (f7_pos),
      .f2_up_f7_neg (f7_neg),
      .f2_up_f8_pos (f8_pos),
      .f2_up_f8_neg (f8_neg),
      .f2_up_t_in   (t_in),
      .f2_up_t_out  (t_out),
      .addr_valid   (addr_valid)
   );

   typedef struct {
      logic        dout;
      int unsigned cnt;
      logic        f7;
      logic        f8;
   } exp_t;

   exp_t        sb_q[$];
   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   int unsigned cur_dig = 0;
   logic        any_gate = 1'b0;
   logic        watch_f7 = 1'b0;
   logic        f7_early = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One digit period: 1 clk pulse + 3 idle clks. Served request is released
   // as soon as xfer_ack is seen, before DONE returns to IDLE.
   task automatic do_digit(input int unsigned d, input logic bitv);
      @(negedge clk);
      cur_dig      = d;
      digit_pulse  = 1'b1;
      mc_sync      = (d == 0);
      order_serial = bitv;
      @(negedge clk);
      digit_pulse  = 1'b0;
      mc_sync      = 1'b0;
      order_serial = 1'b0;
      if (watch_f7 && d < DPM - 1 && f7_pos) f7_early = 1'b1;
      if (xfer_ack) begin
         if (xfer_out_req) xfer_out_req = 1'b0;
         else              xfer_in_req  = 1'b0;
      end
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic run_mc(input logic [DPM-1:0] word, input logic cap,
                         input int unsigned cap_drop, input int unsigned req_dig,
                         input logic set_in, input logic set_out,
                         input int unsigned req_drop);
      addr_capture = cap;
      for (int unsigned d = 0; d < DPM; d++) begin
         if (d == cap_drop) addr_capture = 1'b0;
         if (d == req_dig) begin
            if (set_in)  xfer_in_req  = 1'b1;
            if (set_out) xfer_out_req = 1'b1;
         end
         if (d == req_drop) begin
            xfer_in_req  = 1'b0;
            xfer_out_req = 1'b0;
         end
         do_digit(d, word[d]);
      end
      addr_capture = 1'b0;
   endtask

   task automatic idle_mc();
      run_mc('0, 1'b0, NONE, NONE, 1'b0, 1'b0, NONE);
   endtask

   task automatic drain();
      for (int k = 0; k < 8 && sb_q.size() != 0; k++) idle_mc();
      chk("window_timeout", sb_q.size(), 0);
   endtask

   // Monitor: counts digit pulses covered by each gate (pulse at which it
   // rose through pulse at which it dropped) and checks on xfer_ack.
   initial begin : monitor
      logic        prev_in, prev_out, ovl;
      int unsigned n_in, n_out;
      exp_t        e;
      prev_in = 0; prev_out = 0; ovl = 0; n_in = 0; n_out = 0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            prev_in = 0; prev_out = 0; ovl = 0; n_in = 0; n_out = 0;
         end else begin
            if (t_in || t_out) any_gate = 1'b1;
            if (t_in && t_out) ovl = 1'b1;
            if (digit_pulse) begin
               if (prev_in  || t_in)  n_in++;
               if (prev_out || t_out) n_out++;
            end
            prev_in  = t_in;
            prev_out = t_out;
            if (xfer_ack) begin
               if (sb_q.size() == 0) begin
                  chk("unexpected_ack", 1, 0);
               end else begin
                  e = sb_q.pop_front();
                  chk("win_dir_out", int'(n_out != 0), int'(e.dout));
                  chk("win_len",     e.dout ? n_out : n_in, e.cnt);
                  chk("win_other",   e.dout ? n_in : n_out, 0);
                  chk("win_overlap", ovl, 0);
                  chk("ack_digit",   cur_dig, DPM - 1);
                  chk("win_f7_pos",  f7_pos, e.f7);
                  chk("win_f7_neg",  f7_neg, !e.f7);
                  chk("win_f8_pos",  f8_pos, e.f8);
                  chk("win_f8_neg",  f8_neg, !e.f8);
               end
               ovl = 0; n_in = 0; n_out = 0;
            end
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin : stim
      logic [DPM-1:0] w10, w01;
      w10 = '0; w10[1] = 1'b1;
      w01 = '0; w01[2] = 1'b1;
      rst_n = 0; digit_pulse = 0; mc_sync = 0; order_serial = 0;
      addr_capture = 0; xfer_in_req = 0; xfer_out_req = 0;
      repeat (3) @(negedge clk);
      chk("rst_f7_pos", f7_pos, 0);
      chk("rst_f7_neg", f7_neg, 1);
      chk("rst_f8_pos", f8_pos, 0);
      chk("rst_f8_neg", f8_neg, 1);
      chk("rst_t_in",   t_in, 0);
      chk("rst_t_out",  t_out, 0);
      chk("rst_ack",    xfer_ack, 0);
      chk("rst_valid",  addr_valid, 0);
      rst_n = 1;
      repeat (2) @(negedge clk);

      // Capture F7=1, F8=0; commit only at digit 17.
      watch_f7 = 1;
      run_mc(w10, 1'b1, NONE, NONE, 1'b0, 1'b0, NONE);
      watch_f7 = 0;
      chk("cap_f7_early", f7_early, 0);
      chk("cap_f7_pos", f7_pos, 1);
      chk("cap_f7_neg", f7_neg, 0);
      chk("cap_f8_pos", f8_pos, 0);
      chk("cap_f8_neg", f8_neg, 1);
      chk("cap_valid",  addr_valid, 1);

      // In request raised at digit 5.
      sb_q.push_back('{dout: 1'b0, cnt: WIN, f7: 1'b1, f8: 1'b0});
      run_mc('0, 1'b0, NONE, 5, 1'b1, 1'b0, NONE);
      drain();

      // Both requests: out window first, then in.
      sb_q.push_back('{dout: 1'b1, cnt: WIN, f7: 1'b1, f8: 1'b0});
      sb_q.push_back('{dout: 1'b0, cnt: WIN, f7: 1'b1, f8: 1'b0});
      run_mc('0, 1'b0, NONE, 5, 1'b1, 1'b1, NONE);
      drain();

      // Capture abandoned at digit 10: address unchanged.
      run_mc(w01, 1'b1, 10, NONE, 1'b0, 1'b0, NONE);
      chk("drop_f7_pos", f7_pos, 1);
      chk("drop_f8_pos", f8_pos, 0);
      chk("drop_valid",  addr_valid, 1);

      // Request withdrawn while armed: no window.
      any_gate = 0;
      run_mc('0, 1'b0, NONE, 5, 1'b0, 1'b1, 12);
      idle_mc();
      chk("armed_drop_gate", any_gate, 0);

      // Recapture during the window: old address under the gate, new after.
      run_mc('0, 1'b0, NONE, 5, 1'b0, 1'b1, NONE);
      sb_q.push_back('{dout: 1'b1, cnt: WIN, f7: 1'b1, f8: 1'b0});
      run_mc(w01, 1'b1, NONE, NONE, 1'b0, 1'b0, NONE);
      drain();
      chk("recap_f7_pos", f7_pos, 0);
      chk("recap_f8_pos", f8_pos, 1);
      chk("recap_f8_neg", f8_neg, 0);

      // Asynchronous reset in the middle of an out window (digit 9).
      run_mc('0, 1'b0, NONE, 5, 1'b0, 1'b1, NONE);
      for (int unsigned d = 0; d < 10; d++) do_digit(d, 1'b0);
      chk("pre_rst_t_out", t_out, 1);
      #2;
      rst_n = 0;
      #1;
      chk("mid_rst_t_out",  t_out, 0);
      chk("mid_rst_t_in",   t_in, 0);
      chk("mid_rst_f7_neg", f7_neg, 1);
      chk("mid_rst_f8_neg", f8_neg, 1);
      chk("mid_rst_valid",  addr_valid, 0);
      chk("mid_rst_ack",    xfer_ack, 0);
      xfer_out_req = 0;
      repeat (3) @(negedge clk);
      rst_n = 1;
      repeat (3) @(negedge clk);
      chk("sb_empty", sb_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
